// File: rtl/mac_tx_pattern_gen_if.sv
// MAC TX FIFO write port: data, write strobe and end-of-frame marker, with backpressure.
interface mac_tx_pattern_gen_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] fifo_txd;
  logic              fifo_txen;
  logic              fifo_txlast;
  logic              fifo_full;

  modport master (output fifo_txd, output fifo_txen, output fifo_txlast, input fifo_full);
  modport slave  (input fifo_txd, input fifo_txen, input fifo_txlast, output fifo_full);
endinterface

// File: rtl/mac_tx_pattern_gen.sv
// MAC TX test-frame generator: header plus patterned payload bursts into the TX FIFO,
// honouring FIFO backpressure, inter-frame gaps and abort requests.
module mac_tx_pattern_gen #(
  parameter int unsigned        DATA_W    = 8,
  parameter int unsigned        LEN_W     = 12,
  parameter bit                 HDR_EN    = 1'b1,
  parameter logic [7:0]         HDR0      = 8'h55,
  parameter logic [7:0]         HDR1      = 8'hAA,
  parameter int unsigned        IFG       = 4,
  parameter logic [DATA_W-1:0]  LFSR_POLY = DATA_W'(8'h1D)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               err_i,
  input  logic               fs_i,
  output logic               fd_o,
  input  logic [LEN_W-1:0]   data_len_i,
  input  logic [1:0]         mode_i,
  input  logic [DATA_W-1:0]  seed_i,
  input  logic [7:0]         frames_i,
  output logic               busy_o,
  output logic               err_flag_o,
  mac_tx_pattern_gen_if.master fifo
);

  localparam int unsigned HDR_LEN  = HDR_EN ? 2 : 0;
  localparam int unsigned GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int unsigned GAP_LAST = (IFG > 0) ? IFG - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [7:0]        frame_q, frame_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [7:0]        frames_q, frames_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] walk_q, walk_d;
  logic              err_flag_q, err_flag_d;

  logic [DATA_W-1:0] pat_c;
  logic [DATA_W-1:0] lfsr_next_c;
  logic [DATA_W-1:0] seed_nz_c;
  logic [8:0]        frames_eff_c;
  logic [DATA_W-1:0] txd_c;
  logic              txen_c;
  logic              txlast_c;

  assign lfsr_next_c  = {lfsr_q[DATA_W-2:0], 1'b0} ^ (lfsr_q[DATA_W-1] ? LFSR_POLY : '0);
  assign seed_nz_c    = (seed_q == '0) ? DATA_W'(1) : seed_q;
  assign frames_eff_c = (frames_q == 8'd0) ? 9'd1 : {1'b0, frames_q};

  // Beat value for the current beat_idx; header beats override the payload pattern.
  always_comb begin
    case (mode_q)
      2'd0:    pat_c = seed_q + DATA_W'(beat_q);
      2'd1:    pat_c = seed_q;
      2'd2:    pat_c = lfsr_q;
      default: pat_c = walk_q;
    endcase
    if (HDR_EN && (beat_q == '0)) begin
      pat_c = DATA_W'(HDR0);
    end else if (HDR_EN && (beat_q == LEN_W'(1))) begin
      pat_c = DATA_W'(HDR1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      frame_q    <= '0;
      gap_q      <= '0;
      len_q      <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      frames_q   <= '0;
      lfsr_q     <= '0;
      walk_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      frame_q    <= frame_d;
      gap_q      <= gap_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      frames_q   <= frames_d;
      lfsr_q     <= lfsr_d;
      walk_q     <= walk_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    frame_d    = frame_q;
    gap_d      = gap_q;
    len_d      = len_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    frames_d   = frames_q;
    lfsr_d     = lfsr_q;
    walk_d     = walk_q;
    err_flag_d = err_flag_q;
    txd_c      = '0;
    txen_c     = 1'b0;
    txlast_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fs_i) state_d = ST_HEAD;
      end

      ST_HEAD: begin
        len_d      = data_len_i;
        mode_d     = mode_i;
        seed_d     = seed_i;
        frames_d   = frames_i;
        err_flag_d = 1'b0;
        beat_d     = '0;
        frame_d    = '0;
        gap_d      = '0;
        lfsr_d     = (seed_i == '0) ? DATA_W'(1) : seed_i;
        walk_d     = DATA_W'(1);
        state_d    = (data_len_i == '0) ? ST_DONE : ST_SEND;
        if (err_i) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end
      end

      ST_SEND: begin
        txen_c   = !fifo.fifo_full;
        txlast_c = (beat_q == len_q - LEN_W'(1));
        txd_c    = pat_c;
        // Pattern state only advances on an accepted beat, so a stall repeats the same beat.
        if (txen_c) begin
          beat_d = beat_q + LEN_W'(1);
          walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
          if (beat_q >= LEN_W'(HDR_LEN)) lfsr_d = lfsr_next_c;
          if (txlast_c) begin
            frame_d = frame_q + 8'd1;
            if (({1'b0, frame_q} + 9'd1) < frames_eff_c) begin
              beat_d  = '0;
              gap_d   = '0;
              lfsr_d  = seed_nz_c;
              walk_d  = DATA_W'(1);
              state_d = (IFG == 0) ? ST_SEND : ST_GAP;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        if (err_i) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end
      end

      ST_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_SEND;
        if (err_i) begin
          state_d    = ST_DONE;
          err_flag_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (!fs_i) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign fifo.fifo_txd    = txd_c;
  assign fifo.fifo_txen   = txen_c;
  assign fifo.fifo_txlast = txlast_c;
  assign fd_o             = (state_q == ST_DONE);
  assign busy_o           = (state_q != ST_IDLE);
  assign err_flag_o       = err_flag_q;

endmodule

// File: tb/tb_mac_tx_pattern_gen.sv
// Randomised and directed checks of mac_tx_pattern_gen against a beat-list reference model,
// using one header/IFG=4 instance and one headerless/back-to-back instance.
module tb_mac_tx_pattern_gen;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 12;
  localparam int          IFG_H  = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] d;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fs, err_h, err_n, fifo_full;
  logic [LEN_W-1:0] data_len;
  logic [1:0]       mode;
  logic [7:0]       seed, frames;
  logic             fd_h, busy_h, ef_h, fd_n, busy_n, ef_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t exp_h[$];
  beat_t exp_n[$];
  int    acc_cyc_h[$];
  int    acc_cyc_n[$];
  int    base_h = 0, base_n = 0;
  bit    in_frame_h = 1'b0, in_frame_n = 1'b0;
  bit    rand_full = 1'b0;
  int    full_trig = -1;
  int    run_id = 0;
  int    fired_id = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_tx_pattern_gen_if #(.DATA_W(DATA_W)) if_h ();
  mac_tx_pattern_gen_if #(.DATA_W(DATA_W)) if_n ();
  assign if_h.fifo_full = fifo_full;
  assign if_n.fifo_full = fifo_full;

  mac_tx_pattern_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .HDR_EN(1'b1), .IFG(IFG_H)) dut_h (
    .clk(clk), .rst_n(rst_n), .err_i(err_h), .fs_i(fs), .fd_o(fd_h),
    .data_len_i(data_len), .mode_i(mode), .seed_i(seed), .frames_i(frames),
    .busy_o(busy_h), .err_flag_o(ef_h), .fifo(if_h)
  );

  mac_tx_pattern_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .HDR_EN(1'b0), .IFG(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .err_i(err_n), .fs_i(fs), .fd_o(fd_n),
    .data_len_i(data_len), .mode_i(mode), .seed_i(seed), .frames_i(frames),
    .busy_o(busy_n), .err_flag_o(ef_n), .fifo(if_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference value of beat k of a frame, straight from the pattern rules.
  function automatic logic [7:0] pat(input bit hdr, input int md, input logic [7:0] sd, input int k);
    logic [7:0] v;
    int p;
    p = hdr ? k - 2 : k;
    if (hdr && k == 0) return 8'h55;
    if (hdr && k == 1) return 8'hAA;
    case (md)
      0: return 8'(int'(sd) + k);
      1: return sd;
      2: begin
        v = (sd == 8'd0) ? 8'd1 : sd;
        for (int i = 0; i < p; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        return v;
      end
      default: return 8'(1 << (k % 8));
    endcase
  endfunction

  // Monitors: compare every accepted beat with the model, and check stall/idle bus behaviour.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_h.fifo_txen) begin
        int idx;
        idx = acc_cyc_h.size() - base_h;
        check("h_txen_while_full", 32'(fifo_full), 32'd0);
        if (idx < exp_h.size()) begin
          check("h_txd", 32'(if_h.fifo_txd), 32'(exp_h[idx].d));
          check("h_txlast", 32'(if_h.fifo_txlast), 32'(exp_h[idx].last));
        end else begin
          check("h_extra_beat", 32'(idx), 32'(exp_h.size() - 1));
        end
        acc_cyc_h.push_back(cyc);
        in_frame_h = !if_h.fifo_txlast;
      end else begin
        if (in_frame_h && busy_h && !fd_h) begin
          check("h_stall_needs_full", 32'(fifo_full), 32'd1);
          if ((acc_cyc_h.size() - base_h) < exp_h.size())
            check("h_hold_txd", 32'(if_h.fifo_txd), 32'(exp_h[acc_cyc_h.size() - base_h].d));
        end
        if (!busy_h || fd_h) begin
          check("h_idle_txd", 32'(if_h.fifo_txd), 32'd0);
          in_frame_h = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if_n.fifo_txen) begin
        int idx;
        idx = acc_cyc_n.size() - base_n;
        check("n_txen_while_full", 32'(fifo_full), 32'd0);
        if (idx < exp_n.size()) begin
          check("n_txd", 32'(if_n.fifo_txd), 32'(exp_n[idx].d));
          check("n_txlast", 32'(if_n.fifo_txlast), 32'(exp_n[idx].last));
        end else begin
          check("n_extra_beat", 32'(idx), 32'(exp_n.size() - 1));
        end
        acc_cyc_n.push_back(cyc);
        in_frame_n = !if_n.fifo_txlast;
      end else begin
        if (in_frame_n && busy_n && !fd_n) begin
          check("n_stall_needs_full", 32'(fifo_full), 32'd1);
          if ((acc_cyc_n.size() - base_n) < exp_n.size())
            check("n_hold_txd", 32'(if_n.fifo_txd), 32'(exp_n[acc_cyc_n.size() - base_n].d));
        end
        if (!busy_n || fd_n) begin
          check("n_idle_txd", 32'(if_n.fifo_txd), 32'd0);
          in_frame_n = 1'b0;
        end
      end
    end
  end

  // Backpressure: changes just after the rising edge; optional 3-cycle stall on a chosen beat.
  initial begin
    int hold;
    hold = 0;
    fifo_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        fifo_full = 1'b1;
        hold--;
      end else if (full_trig >= 0 && fired_id != run_id &&
                   (acc_cyc_h.size() - base_h) == full_trig) begin
        fifo_full = 1'b1;
        hold = 2;
        fired_id = run_id;
      end else begin
        fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  task automatic prep(input int len, input int md, input logic [7:0] sd, input int frm);
    beat_t b;
    int nf;
    nf = (frm == 0) ? 1 : frm;
    exp_h.delete();
    exp_n.delete();
    base_h = acc_cyc_h.size();
    base_n = acc_cyc_n.size();
    run_id++;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < len; k++) begin
        b.last = (k == len - 1);
        b.d = pat(1'b1, md, sd, k);
        exp_h.push_back(b);
        b.d = pat(1'b0, md, sd, k);
        exp_n.push_back(b);
      end
    end
    data_len = LEN_W'(len);
    mode     = 2'(md);
    seed     = sd;
    frames   = 8'(frm);
  endtask

  task automatic run(input int len, input int md, input logic [7:0] sd, input int frm,
                     input int err_at, input int full_at, input bit rnd);
    int c0, fdh, fdn, nexp_h, cnt_h, cnt_n;
    bit err_sent;
    prep(len, md, sd, frm);
    nexp_h = (err_at >= 0) ? err_at + 1 : exp_h.size();
    rand_full = rnd;
    full_trig = full_at;
    @(posedge clk);
    #1;
    fs = 1'b1;
    c0 = cyc;
    fdh = -1;
    fdn = -1;
    err_sent = 1'b0;
    for (int i = 0; i < 3000 && (fdh < 0 || fdn < 0); i++) begin
      @(negedge clk);
      #1;
      err_h = 1'b0;
      if (err_at >= 0 && !err_sent && if_h.fifo_txen && (acc_cyc_h.size() - base_h) == err_at + 1) begin
        err_h = 1'b1;
        err_sent = 1'b1;
      end
      if (fd_h && fdh < 0) fdh = cyc;
      if (fd_n && fdn < 0) fdn = cyc;
    end
    err_h = 1'b0;
    rand_full = 1'b0;
    full_trig = -1;
    check("h_fd_seen", 32'(fdh >= 0), 32'd1);
    check("n_fd_seen", 32'(fdn >= 0), 32'd1);
    cnt_h = acc_cyc_h.size() - base_h;
    cnt_n = acc_cyc_n.size() - base_n;
    check("h_beat_count", 32'(cnt_h), 32'(nexp_h));
    check("n_beat_count", 32'(cnt_n), 32'(exp_n.size()));
    check("h_err_flag", 32'(ef_h), 32'(err_at >= 0));
    check("n_err_flag", 32'(ef_n), 32'd0);
    if (len == 0) begin
      check("h_fd_after_head", 32'(fdh), 32'(c0 + 2));
      check("n_fd_after_head", 32'(fdn), 32'(c0 + 2));
    end else begin
      if (err_at < 0 && cnt_h > 0) check("h_fd_latency", 32'(fdh), 32'(acc_cyc_h[$] + 1));
      if (cnt_n > 0) check("n_fd_latency", 32'(fdn), 32'(acc_cyc_n[$] + 1));
    end
    if (!rnd) begin
      for (int i = 1; i < cnt_h; i++) begin
        int e;
        e = ((i % len) == 0) ? IFG_H + 1 : 1;
        if (i == full_at) e += 3;
        check("h_beat_spacing", 32'(acc_cyc_h[base_h + i] - acc_cyc_h[base_h + i - 1]), 32'(e));
      end
      for (int i = 1; i < cnt_n; i++) begin
        int e;
        e = (i == full_at) ? 4 : 1;
        check("n_beat_spacing", 32'(acc_cyc_n[base_n + i] - acc_cyc_n[base_n + i - 1]), 32'(e));
      end
    end
    @(negedge clk);
    check("h_fd_held_with_fs", 32'(fd_h), 32'd1);
    check("n_fd_held_with_fs", 32'(fd_n), 32'd1);
    @(posedge clk);
    #1;
    fs = 1'b0;
    repeat (2) @(negedge clk);
    check("h_back_to_idle", 32'({busy_h, fd_h}), 32'd0);
    check("n_back_to_idle", 32'({busy_n, fd_n}), 32'd0);
  endtask

  initial begin
    fs = 1'b0;
    err_h = 1'b0;
    err_n = 1'b0;
    data_len = '0;
    mode = '0;
    seed = '0;
    frames = '0;
    repeat (3) @(negedge clk);
    check("rst_h_outputs", 32'({fd_h, busy_h, ef_h, if_h.fifo_txen, if_h.fifo_txlast, if_h.fifo_txd}), 32'd0);
    check("rst_n_outputs", 32'({fd_n, busy_n, ef_n, if_n.fifo_txen, if_n.fifo_txlast, if_n.fifo_txd}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(8, 0, 8'h00, 1, -1, -1, 1'b0);    // header + incrementing payload
    run(8, 0, 8'h00, 1, -1, 4, 1'b0);     // 3-cycle stall on beat 4
    run(4, 0, 8'h00, 3, -1, -1, 1'b0);    // 3-frame burst with gaps
    run(10, 2, 8'h01, 1, -1, -1, 1'b0);   // LFSR from seed 1
    run(10, 2, 8'h00, 1, -1, -1, 1'b0);   // LFSR zero seed replaced by 1
    run(12, 3, 8'h00, 1, -1, -1, 1'b0);   // walking one wraps
    run(6, 1, 8'h3C, 0, -1, -1, 1'b0);    // constant, frames=0 acts as 1
    run(8, 0, 8'h00, 1, 3, -1, 1'b0);     // abort on beat 3
    run(8, 0, 8'h00, 1, -1, -1, 1'b0);    // next burst clears err_flag
    run(0, 0, 8'h00, 1, -1, -1, 1'b0);    // empty frame
    run(1, 0, 8'h00, 1, -1, -1, 1'b0);    // single header beat with txlast

    for (int t = 0; t < 12; t++) begin
      int len, frm, err_at, nf;
      len = $urandom_range(0, 20);
      frm = $urandom_range(0, 3);
      nf = (frm == 0) ? 1 : frm;
      err_at = -1;
      if (len > 0 && $urandom_range(0, 2) == 0) err_at = $urandom_range(0, len * nf - 1);
      run(len, $urandom_range(0, 3), 8'($urandom_range(0, 255)), frm, err_at, -1, 1'b1);
    end

    // Reset in the middle of a frame
    prep(12, 0, 8'h10, 1);
    @(posedge clk);
    #1;
    fs = 1'b1;
    for (int i = 0; i < 200 && (acc_cyc_h.size() - base_h) < 5; i++) @(negedge clk);
    check("rst_mid_reached_beat5", 32'((acc_cyc_h.size() - base_h) >= 5), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_h_outputs", 32'({fd_h, busy_h, ef_h, if_h.fifo_txen, if_h.fifo_txlast, if_h.fifo_txd}), 32'd0);
    check("rst_mid_n_outputs", 32'({fd_n, busy_n, ef_n, if_n.fifo_txen, if_n.fifo_txlast, if_n.fifo_txd}), 32'd0);
    fs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_stays_idle", 32'({busy_h, busy_n}), 32'd0);
    run(5, 0, 8'h20, 2, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
